outbuf_cntl: RTL and testbench

OUTBUF_CNTL -- requirements
Module: outbuf_cntl

---
 rtl/outbuf_cntl_if.sv | 28 ++
 rtl/outbuf_cntl.sv | 160 ++++++++++++++++
 tb/tb_outbuf_cntl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/outbuf_cntl_if.sv
// Output-memory write bus of the result buffer controller.
// master: the controller (drives request, address, data; receives ack).
// slave : the output memory (receives the write, returns ack).
interface outbuf_cntl_if #(
  parameter int OUTBUF_MEM_ADDR_W = 4,
  parameter int OUTBUF_MEM_DATA_W = 128
) ();

  logic                         outbuf_mem_wr_req;
  logic [OUTBUF_MEM_ADDR_W-1:0] outbuf_mem_wr_addr;
  logic [OUTBUF_MEM_DATA_W-1:0] outbuf_mem_wr_data;
  logic                         outbuf_mem_wr_ack;

  modport master (
    output outbuf_mem_wr_req,
    output outbuf_mem_wr_addr,
    output outbuf_mem_wr_data,
    input  outbuf_mem_wr_ack
  );

  modport slave (
    input  outbuf_mem_wr_req,
    input  outbuf_mem_wr_addr,
    input  outbuf_mem_wr_data,
    output outbuf_mem_wr_ack
  );

endinterface

// File: rtl/outbuf_cntl.sv
// outbuf_cntl: captures engine result lines and writes them into a circular
// output memory, tracking how many lines are waiting for the host.
// A line is captured on an accepted valid pulse, held one cycle, then
// presented on the memory write bus until acknowledged.
// Optional build macro OUTBUF_LINE_CNT_EN adds a saturating 16-bit count
// of completed memory writes on port outbuf_line_cnt.
module outbuf_cntl #(
  parameter  int PACKET_LENGTH     = 8,
  parameter  int W                 = 4,
  parameter  int OUT_UNIT_NUM      = 4,
  parameter  int OUTBUF_MEM_ADDR_W = 4,
  localparam int OUTBUF_MEM_DATA_W = PACKET_LENGTH * W * OUT_UNIT_NUM
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         eng_rstn,
  input  logic                         cntrl_outbuf_wr_en,
  input  logic [OUTBUF_MEM_DATA_W-1:0] eng_outbuf_dout,
  input  logic                         eng_outbuf_dout_val,
  output logic                         outbuf_eng_stall,
  outbuf_cntl_if.master                mem,
  input  logic                         host_rd_pop,
  output logic [OUTBUF_MEM_ADDR_W:0]   outbuf_level,
  output logic                         outbuf_full,
  output logic                         outbuf_empty,
  output logic                         outbuf_ovf
`ifdef OUTBUF_LINE_CNT_EN
  ,
  output logic [15:0]                  outbuf_line_cnt
`endif
);

  localparam int                       DEPTH    = 1 << OUTBUF_MEM_ADDR_W;
  localparam logic [OUTBUF_MEM_ADDR_W:0] LV_DEPTH = (OUTBUF_MEM_ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    WRITE   = 2'd2
  } state_e;

  state_e                       r_state;
  logic                         r_wr_req;
  logic [OUTBUF_MEM_ADDR_W-1:0] r_wr_addr;
  logic [OUTBUF_MEM_DATA_W-1:0] r_cap_data;
  logic [OUTBUF_MEM_ADDR_W:0]   r_level;
  logic                         r_ovf;

  logic w_accept;
  logic w_drop;
  logic w_wr_done;
  logic w_pop;

  // Engine may only present a line while idle, with room left and capture enabled.
  assign outbuf_eng_stall = (r_state != IDLE) | outbuf_full | ~cntrl_outbuf_wr_en;

  assign w_accept  = eng_outbuf_dout_val & ~outbuf_eng_stall;
  assign w_drop    = eng_outbuf_dout_val &  outbuf_eng_stall;
  assign w_wr_done = (r_state == WRITE) & mem.outbuf_mem_wr_ack;
  assign w_pop     = host_rd_pop & (r_level != '0);

  assign mem.outbuf_mem_wr_req  = r_wr_req;
  assign mem.outbuf_mem_wr_addr = r_wr_addr;
  assign mem.outbuf_mem_wr_data = r_cap_data;

  assign outbuf_level = r_level;
  assign outbuf_full  = (r_level == LV_DEPTH);
  assign outbuf_empty = (r_level == '0);
  assign outbuf_ovf   = r_ovf;

  // Capture/write sequencer; request, address and data are registered and
  // therefore held stable for the whole WRITE state.
  // NOTE: rstn is asynchronous (in the sensitivity list); eng_rstn is a
  // synchronous clear, so it is only tested inside the clocked branch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the wide capture register is reset because the write-data port
      // must read zero after reset; datapath registers usually need no reset.
      r_state    <= IDLE;
      r_wr_req   <= 1'b0;
      r_wr_addr  <= '0;
      r_cap_data <= '0;
    end else if (!eng_rstn) begin
      r_state    <= IDLE;
      r_wr_req   <= 1'b0;
      r_wr_addr  <= '0;
      r_cap_data <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading its
      // pre-edge value, so the order of these statements does not matter.
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cap_data <= eng_outbuf_dout;
            r_state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_wr_req <= 1'b1;
          r_state  <= WRITE;
        end
        WRITE: begin
          if (mem.outbuf_mem_wr_ack) begin
            r_wr_req  <= 1'b0;
            r_wr_addr <= r_wr_addr + 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_wr_req <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  // Occupancy: +1 on completed write, -1 on host pop, unchanged when both.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_level <= '0;
    end else if (!eng_rstn) begin
      r_level <= '0;
    end else begin
      case ({w_wr_done, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky flag: a valid line arrived while the engine was told to stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (!eng_rstn) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

`ifdef OUTBUF_LINE_CNT_EN
  logic [15:0] r_line_cnt;

  assign outbuf_line_cnt = r_line_cnt;

  // Saturating count of acknowledged memory writes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_line_cnt <= '0;
    end else if (!eng_rstn) begin
      r_line_cnt <= '0;
    end else if (w_wr_done && (r_line_cnt != 16'hFFFF)) begin
      r_line_cnt <= r_line_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_outbuf_cntl.sv
// Testbench for outbuf_cntl. Stimulus pushes the expected memory write
// (address, data, request length) into a scoreboard queue; a monitor pops
// and compares whenever the controller completes a write on the bus.
module tb_outbuf_cntl;

  localparam int AW = 4;
  localparam int DW = 128;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cycles;
  } wr_exp_t;

  logic          clk;
  logic          rstn;
  logic          eng_rstn;
  logic          wr_en;
  logic [DW-1:0] dout;
  logic          dout_val;
  logic          stall;
  logic          pop;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          ovf;
`ifdef OUTBUF_LINE_CNT_EN
  logic [15:0]   line_cnt;
`endif

  outbuf_cntl_if #(.OUTBUF_MEM_ADDR_W(AW), .OUTBUF_MEM_DATA_W(DW)) mem_if ();

  outbuf_cntl #(
    .PACKET_LENGTH    (8),
    .W                (4),
    .OUT_UNIT_NUM     (4),
    .OUTBUF_MEM_ADDR_W(AW)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .eng_rstn           (eng_rstn),
    .cntrl_outbuf_wr_en (wr_en),
    .eng_outbuf_dout    (dout),
    .eng_outbuf_dout_val(dout_val),
    .outbuf_eng_stall   (stall),
    .mem                (mem_if.master),
    .host_rd_pop        (pop),
    .outbuf_level       (level),
    .outbuf_full        (full),
    .outbuf_empty       (empty),
    .outbuf_ovf         (ovf)
`ifdef OUTBUF_LINE_CNT_EN
    ,
    .outbuf_line_cnt    (line_cnt)
`endif
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  wr_exp_t       sb[$];
  logic [AW-1:0] exp_addr = '0;
  int            ack_delay = 0;
  int            ack_cnt   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: acknowledge after ack_delay cycles of an asserted request.
  initial begin
    mem_if.outbuf_mem_wr_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_if.outbuf_mem_wr_req) begin
        mem_if.outbuf_mem_wr_ack = 1'b0;
        ack_cnt = 0;
      end else if (ack_cnt == ack_delay) begin
        mem_if.outbuf_mem_wr_ack = 1'b1;
        ack_cnt = 0;
      end else begin
        mem_if.outbuf_mem_wr_ack = 1'b0;
        ack_cnt++;
      end
    end
  end

  // Monitor: checks bus stability during a request and scores each completed write.
  initial begin
    logic          in_req;
    int            cyc;
    logic [AW-1:0] held_addr;
    logic [DW-1:0] held_data;
    wr_exp_t       e;
    in_req = 1'b0;
    cyc    = 0;
    forever begin
      @(negedge clk);
      if (rstn && mem_if.outbuf_mem_wr_req) begin
        if (!in_req) begin
          in_req    = 1'b1;
          cyc       = 1;
          held_addr = mem_if.outbuf_mem_wr_addr;
          held_data = mem_if.outbuf_mem_wr_data;
        end else begin
          cyc++;
          check("wr_addr_stable", DW'(mem_if.outbuf_mem_wr_addr), DW'(held_addr));
          check("wr_data_stable", mem_if.outbuf_mem_wr_data, held_data);
        end
        check("stall_during_write", DW'(stall), DW'(1'b1));
        if (mem_if.outbuf_mem_wr_ack) begin
          in_req = 1'b0;
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected_write: addr %0h data %0h with nothing expected",
                     mem_if.outbuf_mem_wr_addr, mem_if.outbuf_mem_wr_data);
          end else begin
            e = sb.pop_front();
            check("sb_wr_addr", DW'(mem_if.outbuf_mem_wr_addr), DW'(e.addr));
            check("sb_wr_data", mem_if.outbuf_mem_wr_data, e.data);
            check("sb_req_cycles", DW'(cyc), DW'(e.cycles));
          end
        end
      end else begin
        in_req = 1'b0;
      end
    end
  end

  // Present one line when the engine is allowed to; optionally expect its write.
  task automatic send_line(input logic [DW-1:0] d, input int cycles, input bit expect_wr);
    int      n;
    wr_exp_t e;
    n = 0;
    while (stall && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (stall) begin
      check("send_line_stall_timeout", DW'(stall), DW'(1'b0));
    end else begin
      dout     = d;
      dout_val = 1'b1;
      if (expect_wr) begin
        e.addr   = exp_addr;
        e.data   = d;
        e.cycles = cycles;
        sb.push_back(e);
        exp_addr = exp_addr + 1'b1;
      end
      @(negedge clk);
      dout_val = 1'b0;
    end
  endtask

  // Wait until every expected write has completed and the bus is idle.
  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || mem_if.outbuf_mem_wr_req) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || mem_if.outbuf_mem_wr_req)
      check("drain_timeout", DW'(sb.size()), DW'(0));
  endtask

  task automatic pop_lines(input int n);
    for (int i = 0; i < n; i++) begin
      pop = 1'b1;
      @(negedge clk);
      pop = 1'b0;
    end
  endtask

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn     = 1'b0;
    eng_rstn = 1'b1;
    wr_en    = 1'b0;
    dout     = '0;
    dout_val = 1'b0;
    pop      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wr_req", DW'(mem_if.outbuf_mem_wr_req), DW'(1'b0));
    check("rst_wr_addr", DW'(mem_if.outbuf_mem_wr_addr), DW'(0));
    check("rst_wr_data", mem_if.outbuf_mem_wr_data, '0);
    check("rst_level", DW'(level), DW'(0));
    check("rst_empty", DW'(empty), DW'(1'b1));
    check("rst_full", DW'(full), DW'(1'b0));
    check("rst_ovf", DW'(ovf), DW'(1'b0));
    check("rst_stall", DW'(stall), DW'(1'b1));
    rstn = 1'b1;
    @(negedge clk);
    wr_en = 1'b1;
    @(negedge clk);

    // Single line, ack immediately: request exactly two cycles after val
    ack_delay = 0;
    send_line(128'h0123456789ABCDEF0123456789ABCDEF, 1, 1'b1);
    check("lat_req_low_c1", DW'(mem_if.outbuf_mem_wr_req), DW'(1'b0));
    @(negedge clk);
    check("lat_req_high_c2", DW'(mem_if.outbuf_mem_wr_req), DW'(1'b1));
    wait_drain();
    check("single_level", DW'(level), DW'(1));
    check("single_empty", DW'(empty), DW'(1'b0));

    // Ack delayed by 3 cycles: request held 4 cycles, level moves only on ack
    ack_delay = 3;
    send_line(128'hFEDCBA98765432100011223344556677, 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("delay_level_before_ack", DW'(level), DW'(1));
    end
    wait_drain();
    check("delay_level_after_ack", DW'(level), DW'(2));

    // Three more lines to reach level 5
    ack_delay = 0;
    send_line({4{32'hA5A50002}}, 1, 1'b1);
    send_line({4{32'hA5A50003}}, 1, 1'b1);
    send_line({4{32'hA5A50004}}, 1, 1'b1);
    wait_drain();
    check("level_five", DW'(level), DW'(5));

    // Pop in the same cycle as the ack: level unchanged
    send_line({4{32'hA5A50005}}, 1, 1'b1);
    @(negedge clk);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    wait_drain();
    check("pop_ack_same_level", DW'(level), DW'(5));

    // Drain to zero, then a pop at zero is ignored
    pop_lines(5);
    check("pop_to_zero_level", DW'(level), DW'(0));
    pop_lines(1);
    check("underflow_level", DW'(level), DW'(0));
    check("underflow_empty", DW'(empty), DW'(1'b1));

    // Engine reset in the middle of a WRITE at address 7
    send_line({4{32'hA5A50006}}, 1, 1'b1);
    wait_drain();
    ack_delay = 10;
    send_line({4{32'hDEAD0007}}, 0, 1'b0);
    @(negedge clk);
    check("abort_req_high", DW'(mem_if.outbuf_mem_wr_req), DW'(1'b1));
    check("abort_addr_7", DW'(mem_if.outbuf_mem_wr_addr), DW'(7));
    dout     = {4{32'hBAD0BAD0}};
    dout_val = 1'b1;
    @(negedge clk);
    dout_val = 1'b0;
    check("ovf_on_stalled_val", DW'(ovf), DW'(1'b1));
    eng_rstn = 1'b0;
    @(negedge clk);
    eng_rstn = 1'b1;
    exp_addr = '0;
    check("eng_rst_wr_req", DW'(mem_if.outbuf_mem_wr_req), DW'(1'b0));
    check("eng_rst_addr", DW'(mem_if.outbuf_mem_wr_addr), DW'(0));
    check("eng_rst_level", DW'(level), DW'(0));
    check("eng_rst_ovf", DW'(ovf), DW'(1'b0));
    check("eng_rst_empty", DW'(empty), DW'(1'b1));
`ifdef OUTBUF_LINE_CNT_EN
    check("eng_rst_line_cnt", DW'(line_cnt), DW'(0));
`endif

    // Fill all 16 lines, then a 17th val is discarded
    ack_delay = 0;
    for (int i = 0; i < 16; i++) begin
      send_line({4{32'hC0DE0000 | 32'(i)}}, 1, 1'b1);
    end
    wait_drain();
    check("fill_level", DW'(level), DW'(16));
    check("fill_full", DW'(full), DW'(1'b1));
    check("fill_stall", DW'(stall), DW'(1'b1));
    check("fill_addr_wrapped", DW'(mem_if.outbuf_mem_wr_addr), DW'(0));
    dout     = {4{32'h11111111}};
    dout_val = 1'b1;
    @(negedge clk);
    dout_val = 1'b0;
    repeat (3) @(negedge clk);
    check("full_drop_ovf", DW'(ovf), DW'(1'b1));
    check("full_drop_level", DW'(level), DW'(16));
    check("full_drop_no_req", DW'(mem_if.outbuf_mem_wr_req), DW'(1'b0));
`ifdef OUTBUF_LINE_CNT_EN
    check("fill_line_cnt", DW'(line_cnt), DW'(16));
`endif

    // Free the buffer and write four more lines across the wrap (0..3)
    pop_lines(16);
    check("popped_all_empty", DW'(empty), DW'(1'b1));
    for (int i = 0; i < 3; i++) begin
      send_line({4{32'h5EC00000 | 32'(i)}}, 1, 1'b1);
      wait_drain();
      pop_lines(1);
    end
    // Capture disabled while the last line is in flight: write still completes
    send_line({4{32'h5EC00003}}, 1, 1'b1);
    wr_en = 1'b0;
    wait_drain();
    check("wr_en_off_level", DW'(level), DW'(1));
    check("wr_en_off_stall", DW'(stall), DW'(1'b1));
    check("wr_en_off_addr", DW'(mem_if.outbuf_mem_wr_addr), DW'(4));
    pop_lines(1);
    check("final_level", DW'(level), DW'(0));
`ifdef OUTBUF_LINE_CNT_EN
    check("final_line_cnt", DW'(line_cnt), DW'(20));
`endif

    repeat (3) @(negedge clk);
    check("sb_leftover", DW'(sb.size()), DW'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
